// File: rtl/ch_sim_gain_fifo.sv
// Channel-simulator stage: per-sample left-shift gain with saturation and optional
// LFSR pseudo-noise, buffered in a DEPTH-entry FIFO with real backpressure.
module ch_sim_gain_fifo #(
  parameter int          W          = 16,
  parameter int          DEPTH      = 8,
  parameter int          NOISE_BITS = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  input  logic [2*W-1:0] DAT_I,
  input  logic           CYC_I,
  input  logic           STB_I,
  input  logic           WE_I,
  output logic           ACK_O,
  input  logic [2:0]     GAIN_SH_I,
  input  logic           NOISE_EN_I,
  output logic [2*W-1:0] DAT_O,
  output logic           CYC_O,
  output logic           STB_O,
  output logic           WE_O,
  input  logic           ACK_I
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = W + 8;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic signed [EW-1:0] MAX_E = {{9{1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_E = {{9{1'b1}}, {(W-1){1'b0}}};

  function automatic logic signed [W-1:0] sat(input logic signed [EW-1:0] v);
    if (v > MAX_E)      return {1'b0, {(W-1){1'b1}}};
    else if (v < MIN_E) return {1'b1, {(W-1){1'b0}}};
    else                return v[W-1:0];
  endfunction

  // Shift by at most 7 keeps the product inside W+8 bits, so no wrap before saturation.
  function automatic logic signed [EW-1:0] gain_noise(
    input logic signed [W-1:0]          x,
    input logic [2:0]                   sh,
    input logic signed [NOISE_BITS-1:0] n,
    input logic                         en
  );
    logic signed [EW-1:0] xe;
    logic signed [EW-1:0] ne;
    xe = {{8{x[W-1]}}, x};
    ne = en ? {{(EW-NOISE_BITS){n[NOISE_BITS-1]}}, n} : '0;
    return (xe <<< sh) + ne;
  endfunction

  logic                    accept;
  logic                    pop;
  logic                    vld_p1;
  logic signed [W-1:0]     i_p1;
  logic signed [W-1:0]     q_p1;
  logic [15:0]             lfsr;
  logic [15:0]             lfsr_next;
  logic [CW-1:0]           count;
  logic [CW-1:0]           count_next;
  logic [CW-1:0]           remain;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           head_idx;
  logic [2*W-1:0]          mem [DEPTH];

  // Accepted-but-not-popped samples never exceed DEPTH, so a push always has a slot.
  assign ACK_O  = ({1'b0, count} + {{CW{1'b0}}, vld_p1}) < {1'b0, DEPTH_C};
  assign accept = CYC_I & STB_I & WE_I & ACK_O;
  assign pop    = STB_O & ACK_I;
  assign WE_O   = CYC_O;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    count_next = count + CW'(vld_p1) - CW'(pop);
    remain     = count - CW'(pop);
    head_idx   = rd_ptr + AW'(pop);
  end

  // Stage 1: gain, noise and saturation
  always_ff @(posedge CLK_I) begin
    if (accept) begin
      i_p1 <= sat(gain_noise(DAT_I[2*W-1:W], GAIN_SH_I,
                             $signed(lfsr[NOISE_BITS-1:0]), NOISE_EN_I));
      q_p1 <= sat(gain_noise(DAT_I[W-1:0], GAIN_SH_I,
                             $signed(lfsr[15:16-NOISE_BITS]), NOISE_EN_I));
    end
  end

  // Stage 2: FIFO storage
  always_ff @(posedge CLK_I) begin
    if (vld_p1) mem[wr_ptr] <= {i_p1, q_p1};
  end

  // Head register only shows entries already stored before this edge, so a fresh push
  // into an empty FIFO becomes visible one edge after it is written.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      vld_p1 <= 1'b0;
      lfsr   <= LFSR_SEED;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      STB_O  <= 1'b0;
      DAT_O  <= '0;
      CYC_O  <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) lfsr <= lfsr_next;
      if (vld_p1) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= head_idx;
      count  <= count_next;
      STB_O  <= (remain != '0);
      if (remain != '0) DAT_O <= mem[head_idx];
      if (accept)
        CYC_O <= 1'b1;
      else if (!CYC_I && !vld_p1 && (count == '0))
        CYC_O <= 1'b0;
    end
  end

endmodule
